alu_exec_unit: RTL

- Parametrised successor to the combinational ALU decoder: decodes ALUOp/funct3/funct7/OP5 internally and executes the operation.
- Single-cycle ops (add/sub/logic/shift/compare/branch-compare) return a registered result one cycle after accept.
- Optional M-extension subset (MUL, MULHU, DIVU, REMU) runs on an iterative shift-add multiplier or restoring divider.
- Sits in the EX stage; stalls the pipeline via in_ready while an iterative op is in progress.

---
 rtl/alu_exec_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/funct3/funct7 and executes; single-cycle ops plus iterative MUL/MULHU/DIVU/REMU.
// Latency 1 cycle for single-cycle ops, WIDTH+1 for M ops; in_ready drops while an iterative op runs, no output backpressure.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter bit M_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             funct7_0,
    input  logic             OP5,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Lt,
    output logic             Ltu,
    output logic             illegal_op
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opb_q;
    logic               sel_hi_q;
    logic               lt_p_q, ltu_p_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q, lt_q, ltu_q, ill_q, ovld_q;

    logic               accept, is_m, m_legal, sc_ill, lt_c, ltu_c;
    logic [SW-1:0]      shamt;
    logic [WIDTH-1:0]   sc_res, sra_res;
    logic [WIDTH:0]     mul_sum, div_sh;
    logic [WIDTH-1:0]   div_rem, m_res;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, iter_d;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = ovld_q;
    assign Result     = result_q;
    assign Zero       = zero_q;
    assign Lt         = lt_q;
    assign Ltu        = ltu_q;
    assign illegal_op = ill_q;

    assign accept  = in_valid & in_ready;
    assign shamt   = SrcB[SW-1:0];
    assign lt_c    = $signed(SrcA) < $signed(SrcB);
    assign ltu_c   = SrcA < SrcB;
    assign sra_res = $unsigned($signed(SrcA) >>> shamt);
    assign is_m    = (ALUOp == 2'b10) & OP5 & funct7_0;
    assign m_legal = M_EN && ((funct3 == 3'b000) || (funct3 == 3'b011) ||
                              (funct3 == 3'b101) || (funct3 == 3'b111));
    assign sc_ill  = (ALUOp == 2'b11) | (is_m & ~m_legal);

    always_comb begin
        sc_res = '0;
        case (ALUOp)
            2'b00: sc_res = SrcA + SrcB;
            2'b01: sc_res = SrcA - SrcB;
            2'b10: begin
                case (funct3)
                    3'b000: sc_res = (OP5 & funct7_5) ? SrcA - SrcB : SrcA + SrcB;
                    3'b001: sc_res = SrcA << shamt;
                    3'b010: sc_res = {{(WIDTH-1){1'b0}}, lt_c};
                    3'b011: sc_res = {{(WIDTH-1){1'b0}}, ltu_c};
                    3'b100: sc_res = SrcA ^ SrcB;
                    3'b101: begin
                        if (funct7_5) sc_res = sra_res;
                        else          sc_res = SrcA >> shamt;
                    end
                    3'b110: sc_res = SrcA | SrcB;
                    default: sc_res = SrcA & SrcB;
                endcase
            end
            default: sc_res = '0;
        endcase
        if (sc_ill) sc_res = '0;
    end

    // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc holds {remainder, dividend/quotient}; a zero divisor always "fits", giving all-ones quotient.
    assign div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge  = div_sh >= {1'b0, opb_q};
    assign div_rem = div_sh[WIDTH-1:0] - opb_q;
    assign div_nxt = {div_ge ? div_rem : div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};

    assign iter_d = (state_q == MUL) ? mul_nxt : div_nxt;
    assign m_res  = sel_hi_q ? iter_d[2*WIDTH-1:WIDTH] : iter_d[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            sel_hi_q <= 1'b0;
            lt_p_q   <= 1'b0;
            ltu_p_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            lt_q     <= 1'b0;
            ltu_q    <= 1'b0;
            ill_q    <= 1'b0;
            ovld_q   <= 1'b0;
        end else begin
            ovld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_m && m_legal) begin
                            state_q  <= funct3[2] ? DIV : MUL;
                            cnt_q    <= CW'(WIDTH);
                            acc_q    <= {{WIDTH{1'b0}}, funct3[2] ? SrcA : SrcB};
                            opb_q    <= funct3[2] ? SrcB : SrcA;
                            sel_hi_q <= funct3[1];
                            lt_p_q   <= lt_c;
                            ltu_p_q  <= ltu_c;
                        end else begin
                            result_q <= sc_res;
                            zero_q   <= (sc_res == '0);
                            lt_q     <= lt_c;
                            ltu_q    <= ltu_c;
                            ill_q    <= sc_ill;
                            ovld_q   <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_q <= iter_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q  <= IDLE;
                        result_q <= m_res;
                        zero_q   <= (m_res == '0);
                        lt_q     <= lt_p_q;
                        ltu_q    <= ltu_p_q;
                        ill_q    <= 1'b0;
                        ovld_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
